// File: rtl/recovery_supervisor_pkg.sv
// Shared types for the clock recovery supervisor: state encoding, clock-domain bundle
// and the default timer width.
package recovery_supervisor_pkg;

  localparam int SUPERVISOR_TIMER_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACQUIRE = 3'd2,
    LOCKED  = 3'd3,
    RETRY   = 3'd4,
    FAULT   = 3'd5
  } supervisor_state_e;

  typedef struct packed {
    logic clk;
    logic sync_rst;
    logic clk_en;
  } clk_dom_s;

endpackage

// File: rtl/recovery_supervisor_if.sv
// Link between the supervisor and the clock recovery instance.
// The master side is the supervisor; the slave side is the recovery block.
interface recovery_supervisor_if;

  logic recovery_en_o;
  logic clear_state_o;
  logic source_select_o;
  logic fully_locked_in_i;
  logic excessive_drift_violation_i;

  modport master (
    output recovery_en_o,
    output clear_state_o,
    output source_select_o,
    input  fully_locked_in_i,
    input  excessive_drift_violation_i
  );

  modport slave (
    input  recovery_en_o,
    input  clear_state_o,
    input  source_select_o,
    output fully_locked_in_i,
    output excessive_drift_violation_i
  );

endinterface

// File: rtl/recovery_supervisor_lock_qualifier.sv
// Counts consecutive fully_locked cycles while acquiring and flags when the hold target
// is reached. The current cycle's sample counts, so a target of N qualifies on the Nth cycle.
module recovery_supervisor_lock_qualifier #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic                   clk_en,
  input  logic                   active,
  input  logic                   fully_locked,
  input  logic [TIMER_WIDTH-1:0] lock_hold,
  output logic                   qualified
);

  logic [TIMER_WIDTH-1:0] hold;
  logic [TIMER_WIDTH-1:0] target;
  logic [TIMER_WIDTH:0]   hold_inc;

  // A programmed hold of zero would never be reached by an incrementing count, so it means one.
  assign target    = (lock_hold == '0) ? TIMER_WIDTH'(1) : lock_hold;
  assign hold_inc  = {1'b0, hold} + 1'b1;
  assign qualified = active && fully_locked && (hold_inc >= {1'b0, target});

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      hold <= '0;
    end else if (clk_en) begin
      if (!active || !fully_locked) begin
        hold <= '0;
      end else if (hold != '1) begin
        hold <= hold + 1'b1;
      end
    end
  end

endmodule

// File: rtl/recovery_supervisor.sv
// Sequencing controller for the clock recovery block: clears, acquires, retries,
// fails over between pos/neg sources and latches a fault once both are exhausted.
module recovery_supervisor
  import recovery_supervisor_pkg::*;
#(
  parameter int TIMER_WIDTH  = SUPERVISOR_TIMER_WIDTH,
  parameter int RETRY_WIDTH  = 4,
  parameter int CLEAR_CYCLES = 4
) (
  input  clk_dom_s                 sys_dom_i,
  input  logic                     supervisor_en_i,
  input  logic                     preferred_source_i,
  input  logic                     failover_en_i,
  input  logic [TIMER_WIDTH-1:0]   acquire_timeout_i,
  input  logic [TIMER_WIDTH-1:0]   lock_hold_i,
  input  logic [RETRY_WIDTH-1:0]   max_retries_i,
  recovery_supervisor_if.master    rec_if,
  output logic                     locked_o,
  output logic                     lock_lost_o,
  output logic                     fault_o,
  output logic [RETRY_WIDTH-1:0]   retry_count_o,
  output logic [2:0]               state_o
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CLR_W-1:0] CLEAR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  logic clk;
  logic sync_rst;
  logic clk_en;

  supervisor_state_e      state, state_n;
  logic [TIMER_WIDTH-1:0] timer, timer_n;
  logic [RETRY_WIDTH-1:0] retry, retry_n;
  logic [CLR_W-1:0]       clr_cnt, clr_cnt_n;
  logic                   source, source_n;
  logic                   tried, tried_n;
  logic                   lost_n;
  logic                   qualified;

  assign clk      = sys_dom_i.clk;
  assign sync_rst = sys_dom_i.sync_rst;
  assign clk_en   = sys_dom_i.clk_en;

  recovery_supervisor_lock_qualifier #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_lock_qualifier (
    .clk          (clk),
    .sync_rst     (sync_rst),
    .clk_en       (clk_en),
    .active       ((state == ACQUIRE) && supervisor_en_i),
    .fully_locked (rec_if.fully_locked_in_i),
    .lock_hold    (lock_hold_i),
    .qualified    (qualified)
  );

  // Next-state logic; disabling the supervisor overrides every transition.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    retry_n   = retry;
    clr_cnt_n = clr_cnt;
    source_n  = source;
    tried_n   = tried;
    lost_n    = 1'b0;
    if (!supervisor_en_i) begin
      state_n   = IDLE;
      timer_n   = '0;
      retry_n   = '0;
      clr_cnt_n = '0;
      source_n  = 1'b0;
      tried_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = CLEAR;
          source_n  = preferred_source_i;
          retry_n   = '0;
          tried_n   = 1'b0;
          clr_cnt_n = '0;
        end
        CLEAR: begin
          if (clr_cnt == CLEAR_LAST) begin
            state_n   = ACQUIRE;
            timer_n   = '0;
            clr_cnt_n = '0;
          end else begin
            clr_cnt_n = clr_cnt + 1'b1;
          end
        end
        ACQUIRE: begin
          timer_n = (timer == '1) ? timer : timer + 1'b1;
          // A drift violation disqualifies the attempt; a completed lock beats the timeout.
          if (rec_if.excessive_drift_violation_i) begin
            state_n = RETRY;
          end else if (qualified) begin
            state_n = LOCKED;
            retry_n = '0;
          end else if (timer == acquire_timeout_i) begin
            state_n = RETRY;
          end
        end
        LOCKED: begin
          retry_n = '0;
          if (!rec_if.fully_locked_in_i || rec_if.excessive_drift_violation_i) begin
            state_n = RETRY;
            lost_n  = 1'b1;
          end
        end
        RETRY: begin
          clr_cnt_n = '0;
          if (retry < max_retries_i) begin
            retry_n = retry + 1'b1;
            state_n = CLEAR;
          end else if (failover_en_i && !tried) begin
            source_n = ~source;
            retry_n  = '0;
            tried_n  = 1'b1;
            state_n  = CLEAR;
          end else begin
            state_n = FAULT;
          end
        end
        FAULT: begin
          state_n = FAULT;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state                  <= IDLE;
      timer                  <= '0;
      retry                  <= '0;
      clr_cnt                <= '0;
      source                 <= 1'b0;
      tried                  <= 1'b0;
      rec_if.recovery_en_o   <= 1'b0;
      rec_if.clear_state_o   <= 1'b0;
      rec_if.source_select_o <= 1'b0;
      locked_o               <= 1'b0;
      lock_lost_o            <= 1'b0;
      fault_o                <= 1'b0;
      retry_count_o          <= '0;
      state_o                <= IDLE;
    end else if (clk_en) begin
      state                  <= state_n;
      timer                  <= timer_n;
      retry                  <= retry_n;
      clr_cnt                <= clr_cnt_n;
      source                 <= source_n;
      tried                  <= tried_n;
      rec_if.recovery_en_o   <= (state_n == ACQUIRE) || (state_n == LOCKED);
      rec_if.clear_state_o   <= (state_n == CLEAR);
      rec_if.source_select_o <= source_n;
      locked_o               <= (state_n == LOCKED);
      lock_lost_o            <= lost_n;
      fault_o                <= (state_n == FAULT);
      retry_count_o          <= retry_n;
      state_o                <= state_n;
    end
  end

endmodule

// File: tb/tb_recovery_supervisor.sv
// Directed bench for recovery_supervisor: lock, retry, failover, fault, drift loss,
// lock/timeout tie, clock-enable freezing and abort from CLEAR.
module tb_recovery_supervisor;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ACQUIRE = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_RETRY   = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic clk = 1'b0;
  logic sync_rst;
  logic clk_en;
  recovery_supervisor_pkg::clk_dom_s sys_dom;

  logic        supervisor_en;
  logic        preferred;
  logic        failover;
  logic [15:0] timeout;
  logic [15:0] lock_hold;
  logic [3:0]  max_retries;
  logic        locked;
  logic        lock_lost;
  logic        fault;
  logic [3:0]  retry_count;
  logic [2:0]  state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  recovery_supervisor_if rs_if ();

  assign sys_dom = {clk, sync_rst, clk_en};

  always #5 clk = ~clk;

  recovery_supervisor #(
    .TIMER_WIDTH  (16),
    .RETRY_WIDTH  (4),
    .CLEAR_CYCLES (4)
  ) dut (
    .sys_dom_i          (sys_dom),
    .supervisor_en_i    (supervisor_en),
    .preferred_source_i (preferred),
    .failover_en_i      (failover),
    .acquire_timeout_i  (timeout),
    .lock_hold_i        (lock_hold),
    .max_retries_i      (max_retries),
    .rec_if             (rs_if),
    .locked_o           (locked),
    .lock_lost_o        (lock_lost),
    .fault_o            (fault),
    .retry_count_o      (retry_count),
    .state_o            (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    int cycles;
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget) begin
      if (state_o == target) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic restart();
    supervisor_en = 1'b0;
    tick();
    supervisor_en = 1'b1;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1;
    clk_en = 1'b1;
    supervisor_en = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (state_o !== S_IDLE) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected %0d", state_o, S_IDLE); end
    tests_run++;
    if ({rs_if.recovery_en_o, rs_if.clear_state_o, rs_if.source_select_o, locked, lock_lost, fault} !== 6'b0)
      begin tests_failed++; $display("[TB] FAIL reset_outputs: got %b expected 000000", {rs_if.recovery_en_o, rs_if.clear_state_o, rs_if.source_select_o, locked, lock_lost, fault}); end
    tests_run++;
    if (retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_retry: got %0d expected 0", retry_count); end
    supervisor_en = 1'b0;
    sync_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_lock();
    int n_clear;
    bit got_acq;
    preferred = 1'b0; lock_hold = 16'd8; timeout = 16'd1000; max_retries = 4'd2; failover = 1'b0;
    rs_if.fully_locked_in_i = 1'b0;
    supervisor_en = 1'b1;
    n_clear = 0;
    got_acq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rs_if.clear_state_o) n_clear++;
      if (rs_if.recovery_en_o) begin got_acq = 1'b1; break; end
    end
    tests_run++;
    if (!got_acq) begin tests_failed++; $display("[TB] FAIL acquire_start: got 0 expected 1"); end
    tests_run++;
    if (n_clear != 4) begin tests_failed++; $display("[TB] FAIL clear_len: got %0d expected 4", n_clear); end
    repeat (20) tick();
    rs_if.fully_locked_in_i = 1'b1;
    repeat (7) tick();
    tests_run++;
    if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_early: got %0d expected 0", locked); end
    tick();
    tests_run++;
    if (locked !== 1'b1 || state_o !== S_LOCKED) begin tests_failed++; $display("[TB] FAIL lock_hold8: got locked=%0d state=%0d expected 1/%0d", locked, state_o, S_LOCKED); end
    tests_run++;
    if (rs_if.source_select_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_source: got %0d expected 0", rs_if.source_select_o); end
  endtask

  task automatic test_drift_relock();
    int n;
    rs_if.excessive_drift_violation_i = 1'b1;
    tick();
    rs_if.excessive_drift_violation_i = 1'b0;
    tests_run++;
    if (state_o !== S_RETRY || lock_lost !== 1'b1 || rs_if.recovery_en_o !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL drift_retry: got state=%0d lost=%0d en=%0d expected %0d/1/0", state_o, lock_lost, rs_if.recovery_en_o, S_RETRY); end
    tick();
    tests_run++;
    if (state_o !== S_CLEAR || lock_lost !== 1'b0 || retry_count !== 4'd1)
      begin tests_failed++; $display("[TB] FAIL drift_clear: got state=%0d lost=%0d retry=%0d expected %0d/0/1", state_o, lock_lost, retry_count, S_CLEAR); end
    n = 0;
    while (!locked && n < 40) begin tick(); n++; end
    tests_run++;
    if (n != 12) begin tests_failed++; $display("[TB] FAIL relock_time: got %0d expected 12", n); end
    tests_run++;
    if (locked !== 1'b1 || retry_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL relock_retry: got locked=%0d retry=%0d expected 1/0", locked, retry_count); end
  endtask

  task automatic test_retry_fault();
    bit ok;
    int n;
    supervisor_en = 1'b0;
    tick();
    tests_run++;
    if (state_o !== S_IDLE || {rs_if.recovery_en_o, locked, fault} !== 3'b0)
      begin tests_failed++; $display("[TB] FAIL disable_idle: got state=%0d expected %0d", state_o, S_IDLE); end
    timeout = 16'd50; max_retries = 4'd2; failover = 1'b0; rs_if.fully_locked_in_i = 1'b0;
    supervisor_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_state(S_ACQUIRE, 20, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("[TB] FAIL rf_wait_acq%0d: got state=%0d expected %0d", r, state_o, S_ACQUIRE); end
      tests_run++;
      if (retry_count !== 4'(r)) begin tests_failed++; $display("[TB] FAIL rf_retry%0d: got %0d expected %0d", r, retry_count, r); end
      n = 0;
      while (rs_if.recovery_en_o && n < 200) begin n++; tick(); end
      tests_run++;
      if (n != 51 || state_o !== S_RETRY) begin tests_failed++; $display("[TB] FAIL rf_timeout%0d: got %0d cycles state=%0d expected 51/%0d", r, n, state_o, S_RETRY); end
    end
    tick();
    tests_run++;
    if (fault !== 1'b1 || state_o !== S_FAULT || rs_if.recovery_en_o !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL rf_fault: got fault=%0d state=%0d en=%0d expected 1/%0d/0", fault, state_o, rs_if.recovery_en_o, S_FAULT); end
    repeat (5) tick();
    tests_run++;
    if (fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL rf_sticky: got %0d expected 1", fault); end
  endtask

  task automatic test_reset_in_fault();
    sync_rst = 1'b1;
    tick();
    tests_run++;
    if (fault !== 1'b0 || state_o !== S_IDLE) begin tests_failed++; $display("[TB] FAIL rst_fault: got fault=%0d state=%0d expected 0/%0d", fault, state_o, S_IDLE); end
    supervisor_en = 1'b0;
    sync_rst = 1'b0;
    tick();
  endtask

  task automatic test_failover();
    bit ok;
    int n;
    timeout = 16'd50; max_retries = 4'd2; failover = 1'b1; rs_if.fully_locked_in_i = 1'b0; preferred = 1'b0;
    restart();
    for (int r = 0; r < 6; r++) begin
      wait_state(S_ACQUIRE, 20, ok);
      tests_run++;
      if (!ok || retry_count !== 4'(r % 3) || rs_if.source_select_o !== (r >= 3))
        begin tests_failed++; $display("[TB] FAIL fo_round%0d: got ok=%0d retry=%0d src=%0d expected 1/%0d/%0d", r, ok, retry_count, rs_if.source_select_o, r % 3, r >= 3); end
      n = 0;
      while (rs_if.recovery_en_o && n < 200) begin n++; tick(); end
      if (r == 2) begin
        tests_run++;
        if (state_o !== S_RETRY || rs_if.source_select_o !== 1'b0)
          begin tests_failed++; $display("[TB] FAIL fo_retry_src: got state=%0d src=%0d expected %0d/0", state_o, rs_if.source_select_o, S_RETRY); end
        tick();
        tests_run++;
        if (state_o !== S_CLEAR || rs_if.source_select_o !== 1'b1 || rs_if.recovery_en_o !== 1'b0)
          begin tests_failed++; $display("[TB] FAIL fo_switch: got state=%0d src=%0d en=%0d expected %0d/1/0", state_o, rs_if.source_select_o, rs_if.recovery_en_o, S_CLEAR); end
      end
    end
    tick();
    tests_run++;
    if (fault !== 1'b1 || rs_if.source_select_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL fo_fault: got fault=%0d src=%0d expected 1/1", fault, rs_if.source_select_o); end
  endtask

  task automatic test_lock_vs_timeout();
    bit ok;
    int n;
    timeout = 16'd10; failover = 1'b0; max_retries = 4'd2; rs_if.fully_locked_in_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lock_hold = (k == 0) ? 16'd11 : 16'd12;
      restart();
      wait_state(S_ACQUIRE, 20, ok);
      n = 0;
      while (ok && state_o == S_ACQUIRE && n < 50) begin n++; tick(); end
      tests_run++;
      if (n != 11 || state_o !== ((k == 0) ? S_LOCKED : S_RETRY))
        begin tests_failed++; $display("[TB] FAIL tie_hold%0d: got %0d cycles state=%0d expected 11/%0d", lock_hold, n, state_o, (k == 0) ? S_LOCKED : S_RETRY); end
    end
    lock_hold = 16'd0;
    restart();
    wait_state(S_ACQUIRE, 20, ok);
    tick();
    tests_run++;
    if (!ok || state_o !== S_LOCKED) begin tests_failed++; $display("[TB] FAIL hold_zero: got state=%0d expected %0d", state_o, S_LOCKED); end
  endtask

  task automatic test_clk_en();
    bit ok;
    int n;
    timeout = 16'd20; max_retries = 4'd2; rs_if.fully_locked_in_i = 1'b0;
    restart();
    wait_state(S_ACQUIRE, 20, ok);
    n = 0;
    while (ok && state_o == S_ACQUIRE && n < 200) begin
      clk_en = ~clk_en;
      tick();
      n++;
    end
    clk_en = 1'b1;
    tests_run++;
    if (n != 42 || state_o !== S_RETRY) begin tests_failed++; $display("[TB] FAIL clk_en_timeout: got %0d cycles state=%0d expected 42/%0d", n, state_o, S_RETRY); end
  endtask

  task automatic test_abort_clear();
    preferred = 1'b1;
    restart();
    tick();
    tests_run++;
    if (state_o !== S_CLEAR || rs_if.source_select_o !== 1'b1 || rs_if.clear_state_o !== 1'b1)
      begin tests_failed++; $display("[TB] FAIL pref_neg: got state=%0d src=%0d clr=%0d expected %0d/1/1", state_o, rs_if.source_select_o, rs_if.clear_state_o, S_CLEAR); end
    tick();
    supervisor_en = 1'b0;
    clk_en = 1'b0;
    tick();
    tests_run++;
    if (state_o !== S_CLEAR) begin tests_failed++; $display("[TB] FAIL frozen_clear: got %0d expected %0d", state_o, S_CLEAR); end
    clk_en = 1'b1;
    tick();
    tests_run++;
    if (state_o !== S_IDLE || {rs_if.recovery_en_o, rs_if.clear_state_o, rs_if.source_select_o, locked, lock_lost, fault, retry_count} !== 10'b0)
      begin tests_failed++; $display("[TB] FAIL abort_idle: got state=%0d outs=%b expected %0d/0", state_o, {rs_if.recovery_en_o, rs_if.clear_state_o, rs_if.source_select_o, locked, lock_lost, fault, retry_count}, S_IDLE); end
  endtask

  initial begin
    sync_rst = 1'b1;
    clk_en = 1'b1;
    supervisor_en = 1'b0;
    preferred = 1'b0;
    failover = 1'b0;
    timeout = 16'd1000;
    lock_hold = 16'd8;
    max_retries = 4'd2;
    rs_if.fully_locked_in_i = 1'b0;
    rs_if.excessive_drift_violation_i = 1'b0;
    test_reset();
    test_basic_lock();
    test_drift_relock();
    test_retry_fault();
    test_reset_in_fault();
    test_failover();
    test_lock_vs_timeout();
    test_clk_en();
    test_abort_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
